// File: rtl/ovl_increment_multi.sv
// Multi-channel increment/decrement checker.
// Each channel monitors one counter field of test_expr. The checker flags any
// step that falls outside [MIN_STEP, MAX_STEP] in the configured direction.
// Holds and modular wrap-around are legal only when their enables are set.
module ovl_increment_multi #(
    parameter int NUM_CH     = 4,
    parameter int WIDTH      = 8,
    parameter int MIN_STEP   = 1,
    parameter int MAX_STEP   = 1,
    parameter int DIR        = 0,
    parameter int ALLOW_HOLD = 0,
    parameter int WRAP_EN    = 1,
    parameter int CNT_W      = 8,
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    clear,
    input  logic [NUM_CH*WIDTH-1:0] test_expr,
    input  logic [NUM_CH-1:0]       sample_valid,
    output logic [NUM_CH-1:0]       fire,
    output logic [CNT_W-1:0]        err_count,
    output logic                    first_fail_vld,
    output logic [CH_W-1:0]         first_fail_ch
);

    // The adder is wide enough to hold err_count plus a popcount of up to 32
    // channels, so saturation is a simple compare with no overflow.
    localparam int SUM_W = CNT_W + 7;
    localparam logic [WIDTH-1:0] MIN_V     = WIDTH'(MIN_STEP);
    localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MAX_STEP);
    localparam logic [SUM_W-1:0] CNT_MAX_W = SUM_W'({CNT_W{1'b1}});

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } ch_state_e;

    ch_state_e        state_q [NUM_CH];
    ch_state_e        state_d [NUM_CH];
    logic [WIDTH-1:0] prev_q  [NUM_CH];
    logic [WIDTH-1:0] prev_d  [NUM_CH];
    logic [NUM_CH-1:0] viol;

    logic [SUM_W-1:0] pop;
    logic [SUM_W-1:0] sum;
    logic [CNT_W-1:0] err_next;
    logic [CH_W-1:0]  first_idx;

    // Per-channel step evaluation in WIDTH-bit modular arithmetic.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] delta;
        logic             wrapped;
        logic             step_bad;

        assign cur     = test_expr[c*WIDTH +: WIDTH];
        assign delta   = (DIR != 0) ? (prev_q[c] - cur) : (cur - prev_q[c]);
        assign wrapped = (DIR != 0) ? (cur > prev_q[c]) : (cur < prev_q[c]);

        assign step_bad = (delta == '0) ? (ALLOW_HOLD == 0)
                        : ((delta < MIN_V) || (delta > MAX_V) || (wrapped && (WRAP_EN == 0)));

        // Only armed channels with a fresh sample are judged; a first sample
        // just seeds prev.
        assign viol[c] = enable && !clear && sample_valid[c]
                       && (state_q[c] == ARMED) && step_bad;
    end

    // Next-state: disable/clear drop every channel to IDLE, a valid sample arms it.
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            // NOTE: every always_comb output gets a default first so no path
            // leaves it unassigned, which would infer a latch.
            state_d[c] = state_q[c];
            prev_d[c]  = prev_q[c];
            if (!enable || clear) begin
                state_d[c] = IDLE;
            end else if (sample_valid[c]) begin
                state_d[c] = ARMED;
                prev_d[c]  = test_expr[c*WIDTH +: WIDTH];
            end
        end
    end

    // Statistics: saturating violation total and lowest violating channel.
    always_comb begin
        pop = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            pop = pop + SUM_W'(viol[c]);
        end
        sum      = SUM_W'(err_count) + pop;
        err_next = (sum > CNT_MAX_W) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];

        first_idx = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (viol[c]) begin
                first_idx = CH_W'(c);
            end
        end
    end

    // Channel state and previous-sample registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            // NOTE: prev is an array but still reset here, because a
            // defined zero value after reset is part of the block's contract.
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= IDLE;
                prev_q[c]  <= '0;
            end
        end else begin
            // NOTE: sequential state uses non-blocking assignments so all
            // registers update together from pre-edge values.
            for (int c = 0; c < NUM_CH; c++) begin
                state_q[c] <= state_d[c];
                prev_q[c]  <= prev_d[c];
            end
        end
    end

    // Registered outputs: fire pulses, error count, first-failure capture.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            fire           <= '0;
            err_count      <= '0;
            first_fail_vld <= 1'b0;
            first_fail_ch  <= '0;
        end else if (clear) begin
            fire           <= '0;
            err_count      <= '0;
            first_fail_vld <= 1'b0;
            first_fail_ch  <= '0;
        end else begin
            fire      <= viol;
            err_count <= err_next;
            if (!first_fail_vld && (|viol)) begin
                first_fail_vld <= 1'b1;
                first_fail_ch  <= first_idx;
            end
        end
    end

endmodule

// File: tb/tb_ovl_increment_multi.sv
// Directed bench for ovl_increment_multi across four parameter sets that share
// clock, reset, enable and clear.
module tb_ovl_increment_multi;

    logic clock = 1'b0;
    logic reset;
    logic enable;
    logic clear;

    always #5 clock = ~clock;

    // A: 1 ch, 2 bit, defaults (wrap legal)
    logic [1:0] te_a;   logic sv_a;
    logic       fire_a; logic [7:0] err_a; logic vld_a; logic ch_a;
    // B: 1 ch, 2 bit, wrap illegal, 2-bit counter
    logic [1:0] te_b;   logic sv_b;
    logic       fire_b; logic [1:0] err_b; logic vld_b; logic ch_b;
    // C: 4 ch, 8 bit, step 1..2
    logic [31:0] te_c;  logic [3:0] sv_c;
    logic [3:0]  fire_c; logic [7:0] err_c; logic vld_c; logic [1:0] ch_c;
    // D: 1 ch, 8 bit, decrement, hold legal
    logic [7:0] te_d;   logic sv_d;
    logic       fire_d; logic [7:0] err_d; logic vld_d; logic ch_d;

    ovl_increment_multi #(.NUM_CH(1), .WIDTH(2)) u_a (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .test_expr(te_a), .sample_valid(sv_a), .fire(fire_a),
        .err_count(err_a), .first_fail_vld(vld_a), .first_fail_ch(ch_a));

    ovl_increment_multi #(.NUM_CH(1), .WIDTH(2), .WRAP_EN(0), .CNT_W(2)) u_b (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .test_expr(te_b), .sample_valid(sv_b), .fire(fire_b),
        .err_count(err_b), .first_fail_vld(vld_b), .first_fail_ch(ch_b));

    ovl_increment_multi #(.NUM_CH(4), .WIDTH(8), .MIN_STEP(1), .MAX_STEP(2)) u_c (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .test_expr(te_c), .sample_valid(sv_c), .fire(fire_c),
        .err_count(err_c), .first_fail_vld(vld_c), .first_fail_ch(ch_c));

    ovl_increment_multi #(.NUM_CH(1), .WIDTH(8), .DIR(1), .ALLOW_HOLD(1)) u_d (
        .clock(clock), .reset(reset), .enable(enable), .clear(clear),
        .test_expr(te_d), .sample_valid(sv_d), .fire(fire_d),
        .err_count(err_d), .first_fail_vld(vld_d), .first_fail_ch(ch_d));

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance through one rising edge and settle 1 time unit after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0;
        te_a = '0; sv_a = 1'b0; te_b = '0; sv_b = 1'b0;
        te_c = '0; sv_c = '0;   te_d = '0; sv_d = 1'b0;
        #2;
        check("rst_fire_c", 32'(fire_c), 0);
        check("rst_err_c",  32'(err_c),  0);
        check("rst_vld_c",  32'(vld_c),  0);
        check("rst_ch_c",   32'(ch_c),   0);
        #6;
        reset = 1'b0; enable = 1'b1;

        // A: 0,1,2,3,0 with legal wrap 3->0
        sv_a = 1'b1;
        te_a = 2'd0; step(); check("a_s0", 32'(fire_a), 0);
        te_a = 2'd1; step(); check("a_s1", 32'(fire_a), 0);
        te_a = 2'd2; step(); check("a_s2", 32'(fire_a), 0);
        te_a = 2'd3; step(); check("a_s3", 32'(fire_a), 0);
        te_a = 2'd0; step(); check("a_wrap", 32'(fire_a), 0);
        sv_a = 1'b0;
        check("a_err", 32'(err_a), 0);

        // B: 2,3,0 with wrap illegal
        sv_b = 1'b1;
        te_b = 2'd2; step(); check("b_s2", 32'(fire_b), 0);
        te_b = 2'd3; step(); check("b_s3", 32'(fire_b), 0);
        te_b = 2'd0; step(); check("b_wrap_fire", 32'(fire_b), 1);
        sv_b = 1'b0; step();
        check("b_pulse_end", 32'(fire_b), 0);
        check("b_err",       32'(err_b),  1);
        check("b_vld",       32'(vld_b),  1);
        check("b_ch",        32'(ch_b),   0);

        // B: five hold violations, counter saturates at 3
        sv_b = 1'b1; te_b = 2'd0;
        step(); check("b_sat1", 32'(err_b), 2);
        step(); check("b_sat2", 32'(err_b), 3);
        step(); check("b_sat3", 32'(err_b), 3);
        step(); check("b_sat4", 32'(err_b), 3);
        step(); check("b_sat5", 32'(err_b), 3);
        check("b_hold_fire", 32'(fire_b), 1);

        // Clear wins over the sample at the same edge
        clear = 1'b1; step(); clear = 1'b0;
        check("b_clr_err",  32'(err_b),  0);
        check("b_clr_vld",  32'(vld_b),  0);
        check("b_clr_fire", 32'(fire_b), 0);
        te_b = 2'd3; step(); check("b_post_clr_first", 32'(fire_b), 0);
        te_b = 2'd3; step(); check("b_post_clr_hold",  32'(fire_b), 1);
        check("b_post_clr_err", 32'(err_b), 1);
        sv_b = 1'b0;

        // C: ch1 5,7,10 and ch3 1,1
        te_c = {8'd0, 8'd0, 8'd5, 8'd0};  sv_c = 4'b0010; step();
        check("c_cyc1", 32'(fire_c), 0);
        te_c = {8'd1, 8'd0, 8'd7, 8'd0};  sv_c = 4'b1010; step();
        check("c_cyc2", 32'(fire_c), 0);
        te_c = {8'd1, 8'd0, 8'd10, 8'd0}; sv_c = 4'b1010; step();
        check("c_multi_fire", 32'(fire_c), 32'b1010);
        check("c_err2", 32'(err_c), 2);
        check("c_vld",  32'(vld_c), 1);
        check("c_ch1",  32'(ch_c),  1);
        // ch0 0 then 9 (fails), ch2 255 then 1 (legal wrap)
        te_c = {8'd0, 8'd255, 8'd0, 8'd0}; sv_c = 4'b0101; step();
        check("c_cyc4", 32'(fire_c), 0);
        te_c = {8'd0, 8'd1, 8'd0, 8'd9};   sv_c = 4'b0101; step();
        check("c_ch0_fire", 32'(fire_c), 32'b0001);
        check("c_err3",     32'(err_c),  3);
        check("c_ch_held",  32'(ch_c),   1);
        sv_c = '0;

        // D: decrement 9,9,8,6 with hold legal
        sv_d = 1'b1;
        te_d = 8'd9; step(); check("d_s9",   32'(fire_d), 0);
        te_d = 8'd9; step(); check("d_hold", 32'(fire_d), 0);
        te_d = 8'd8; step(); check("d_s8",   32'(fire_d), 0);
        te_d = 8'd6; step(); check("d_big_step", 32'(fire_d), 1);
        check("d_err", 32'(err_d), 1);

        // enable=0 suppresses checks and drops fire
        enable = 1'b0; te_d = 8'd0; step();
        check("d_dis_fire", 32'(fire_d), 0);
        enable = 1'b1; te_d = 8'd0; step();
        check("d_reenable_first", 32'(fire_d), 0);
        te_d = 8'd255; step();
        check("d_dec_wrap", 32'(fire_d), 0);
        check("d_err_kept", 32'(err_d), 1);
        sv_d = 1'b0;

        // Reset mid-run on C ch0: 4,5,6,9 then async reset
        sv_c = 4'b0001;
        te_c = 32'd4; step();
        te_c = 32'd5; step();
        te_c = 32'd6; step(); check("c_run_ok", 32'(fire_c), 0);
        te_c = 32'd9; step(); check("c_pre_rst_fire", 32'(fire_c), 32'b0001);
        check("c_pre_rst_err", 32'(err_c), 4);
        sv_c = '0;
        #2; reset = 1'b1; #1;
        check("c_rst_fire", 32'(fire_c), 0);
        check("c_rst_err",  32'(err_c),  0);
        check("c_rst_vld",  32'(vld_c),  0);
        #1; reset = 1'b0;
        sv_c = 4'b0001;
        te_c = 32'd7;  step(); check("c_after_rst_first", 32'(fire_c), 0);
        te_c = 32'd8;  step(); check("c_after_rst_pass",  32'(fire_c), 0);
        te_c = 32'd11; step(); check("c_after_rst_fail",  32'(fire_c), 32'b0001);
        check("c_after_rst_err", 32'(err_c), 1);
        sv_c = '0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/ovl_increment_multi.md
Name: ovl_increment_multi

Overview:
- Parametrised, multi-channel successor to the single-channel OVL increment checker.
- Monitors NUM_CH independent counters packed on one bus. On each sampled value, checks that the step from that channel's previous sample lies in [MIN_STEP, MAX_STEP], in the configured direction.
- Optional hold and wrap-around acceptance.
- Reports per-channel fire pulses, a saturating violation count and the first failing channel.
- Instantiated in ivl_uvm OVL tests beside ovl_always/ovl_increment.

Parameters:
- NUM_CH, 4: number of monitored channels (1..32)
- WIDTH, 8: bits per channel value (2..32)
- MIN_STEP, 1: minimum legal nonzero step (1..MAX_STEP)
- MAX_STEP, 1: maximum legal step (< 2^WIDTH)
- DIR, 0: 0 = increment check, 1 = decrement check
- ALLOW_HOLD, 0: 1 = step of 0 is legal
- WRAP_EN, 1: 1 = modular wrap past max/min is legal
- CNT_W, 8: width of err_count

Ports:
- clock  in  1  sampling clock, rising edge
- reset  in  1  asynchronous, active-high reset
- enable  in  1  global check enable
- clear  in  1  synchronous clear of state and statistics
- test_expr  in  NUM_CH*WIDTH  channel c occupies bits [c*WIDTH +: WIDTH]
- sample_valid  in  NUM_CH  channel c value is sampled this edge
- fire  out  NUM_CH  one-cycle violation pulse per channel
- err_count  out  CNT_W  saturating total of violations
- first_fail_vld  out  1  a violation has occurred since reset/clear
- first_fail_ch  out  $clog2(NUM_CH) (min 1)  lowest channel index of the first violating cycle

Behaviour:
- Reset (async, reset=1):
  - fire=0, err_count=0, first_fail_vld=0, first_fail_ch=0.
  - All channels go to IDLE; prev registers cleared.
- Per-channel FSM, IDLE -> ARMED:
  - IDLE: a valid sample stores prev and moves to ARMED. No check is made on this sample.
  - ARMED: a valid sample is checked, then prev is updated with the current value whether the check passes or fails.
  - enable=0 or clear=1 at an edge: all channels return to IDLE. The next sample is a fresh first sample.
- Step computation, WIDTH-bit modular arithmetic:
  - DIR=0: delta = cur - prev. Wrapped when cur < prev.
  - DIR=1: delta = prev - cur. Wrapped when cur > prev.
- Violation when any of the following holds:
  - delta==0 and ALLOW_HOLD=0.
  - delta!=0 and (delta<MIN_STEP or delta>MAX_STEP).
  - wrapped, delta!=0 and WRAP_EN=0.
- Timing and output rules:
  - fire[c] is registered: it asserts the cycle after the violating sample edge, for exactly one cycle.
  - No valid sample -> fire[c]=0 and prev is held.
  - err_count adds popcount of the violations detected at each edge, saturating at 2^CNT_W-1 with no rollover.
  - First violating edge after reset/clear: first_fail_vld=1 and first_fail_ch = lowest violating index. Both are held until reset or clear; later failures do not change them.
- clear=1:
  - Synchronous: fire, err_count, first_fail_* go to 0 and channels go to IDLE.
  - clear has priority over sampling at the same edge.
- enable=0: no checks are made; fire is 0 from the next cycle.
- Reset mid-run: outputs drop immediately (async). After release, each channel needs a new first sample.
- Channels are fully independent; simultaneous violations on several channels are all reported.

Test Plan:
- NUM_CH=1, WIDTH=2, defaults; reset, then samples 0,1,2,3,0 -> fire never asserts (wrap 3->0 legal); err_count=0.
- Same config with WRAP_EN=0, samples 2,3,0 -> fire[0]=1 exactly one cycle after the 0 sample; err_count=1; first_fail_ch=0.
- NUM_CH=4, MIN_STEP=1, MAX_STEP=2; ch1 samples 5,7,10 and ch3 samples 1,1 in the same cycles -> fire=4'b1010 the cycle after the third/second samples; err_count=2; first_fail_ch=1.
- DIR=1, ALLOW_HOLD=1; samples 9,9,8,6 -> hold accepted, step 8->6 (delta 2 > MAX_STEP=1) fires; err_count=1.
- CNT_W=2, 5 consecutive violating samples -> err_count saturates at 3. Then clear=1 -> err_count=0, first_fail_vld=0, and the next sample is not checked.
- Assert reset mid-sequence between samples 4 and 7 -> fire and err_count are 0 immediately. After release, sample 7 is not checked (IDLE) and sample 8 passes.
